jk_mod_counter: RTL and testbench

//  Parametrised synchronous up/down modulo-N counter built from per-bit JK flip-flop cells.

---
 rtl/jk_mod_counter_pkg.sv | 17 +
 rtl/jk_ff_cell.sv | 50 +++++
 rtl/jk_mod_counter.sv | 87 ++++++++
 tb/tb_jk_mod_counter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/jk_mod_counter_pkg.sv
// Shared definitions for the JK-cell based modulo counter: excitation codes
// and the helper that derives a cell's {J,K} pair from its present/next state.
package jk_mod_counter_pkg;

    // JK excitation codes, packed as {J, K}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Minimal excitation: J only when rising 0->1, K only when falling 1->0.
    // The toggle code is never produced, which keeps every transition explicit.
    function automatic logic [1:0] jk_excite(input logic q, input logic nxt);
        return {~q & nxt, q & ~nxt};
    endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// Single JK flip-flop cell with synchronous active-high reset.
// The active clock edge is chosen at elaboration time by NEG_EDGE.
module jk_ff_cell
    import jk_mod_counter_pkg::*;
#(
    parameter bit NEG_EDGE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    logic r_q;
    logic w_q_nxt;

    // Classic JK table: hold / reset / set / toggle
    always_comb begin
        w_q_nxt = r_q;
        case ({j, k})
            JK_HOLD: w_q_nxt = r_q;
            JK_RST:  w_q_nxt = 1'b0;
            JK_SET:  w_q_nxt = 1'b1;
            JK_TGL:  w_q_nxt = ~r_q;
            default: w_q_nxt = r_q;
        endcase
    end

    generate
        if (NEG_EDGE) begin : g_neg
            // State register updated on the falling edge; reset has priority
            always_ff @(negedge clk) begin
                if (reset) r_q <= 1'b0;
                else       r_q <= w_q_nxt;
            end
        end else begin : g_pos
            // State register updated on the rising edge; reset has priority
            always_ff @(posedge clk) begin
                if (reset) r_q <= 1'b0;
                else       r_q <= w_q_nxt;
            end
        end
    endgenerate

    assign q    = r_q;
    assign qbar = ~r_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Synchronous up/down modulo-MODULUS counter. The next count is computed
// combinationally, converted to per-bit J/K excitation, and stored in a row of
// jk_ff_cell instances. Priority on each active edge: reset > load > en > hold.
module jk_mod_counter
    import jk_mod_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter bit NEG_EDGE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_n,
    output logic             tc,
    output logic             load_err
);

    // Largest legal count, truncated to the counter width so that
    // MODULUS == 2**WIDTH becomes all ones and wraps naturally.
    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qbar;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_load_ok;
    logic             r_load_err;

    // Next-count selection; an out-of-range count counting up goes to 0,
    // counting down it decrements and so always drifts back into range.
    always_comb begin
        w_nxt     = w_q;
        w_load_ok = (load_val <= C_MAX);
        if (load) begin
            w_nxt = w_load_ok ? load_val : C_MAX;
        end else if (en) begin
            if (up_dn) w_nxt = (w_q >= C_MAX) ? '0 : (w_q + C_ONE);
            else       w_nxt = (w_q == '0) ? C_MAX : (w_q - C_ONE);
        end
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign {w_j[i], w_k[i]} = jk_excite(w_q[i], w_nxt[i]);

            jk_ff_cell #(
                .NEG_EDGE (NEG_EDGE)
            ) u_cell (
                .clk  (clk),
                .reset(reset),
                .j    (w_j[i]),
                .k    (w_k[i]),
                .q    (w_q[i]),
                .qbar (w_qbar[i])
            );
        end

        if (NEG_EDGE) begin : g_err_neg
            // Load-error flag: set only by an out-of-range load, cleared otherwise
            always_ff @(negedge clk) begin
                if (reset) r_load_err <= 1'b0;
                else       r_load_err <= load & ~w_load_ok;
            end
        end else begin : g_err_pos
            // Load-error flag: set only by an out-of-range load, cleared otherwise
            always_ff @(posedge clk) begin
                if (reset) r_load_err <= 1'b0;
                else       r_load_err <= load & ~w_load_ok;
            end
        end
    endgenerate

    assign count    = w_q;
    assign count_n  = w_qbar;
    assign load_err = r_load_err;
    // Terminal count: high during the cycle whose active edge wraps the counter
    assign tc       = en & ((up_dn & (w_q == C_MAX)) | (~up_dn & (w_q == '0)));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter: a falling-edge W=4/M=10 instance and a
// rising-edge W=3/M=8 instance share one clock.
module tb_jk_mod_counter;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: WIDTH=4, MODULUS=10, falling edge ----------------
    logic       reset, en, up_dn, load;
    logic [3:0] load_val;
    logic [3:0] count, count_n;
    logic       tc, load_err;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10), .NEG_EDGE(1'b1)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .up_dn   (up_dn),
        .load    (load),
        .load_val(load_val),
        .count   (count),
        .count_n (count_n),
        .tc      (tc),
        .load_err(load_err)
    );

    // ---------------- DUT B: WIDTH=3, MODULUS=8, rising edge ----------------
    logic       b_reset, b_en, b_up_dn, b_load;
    logic [2:0] b_load_val;
    logic [2:0] b_count, b_count_n;
    logic       b_tc, b_load_err;

    jk_mod_counter #(.WIDTH(3), .MODULUS(8), .NEG_EDGE(1'b0)) dut_b (
        .clk     (clk),
        .reset   (b_reset),
        .en      (b_en),
        .up_dn   (b_up_dn),
        .load    (b_load),
        .load_val(b_load_val),
        .count   (b_count),
        .count_n (b_count_n),
        .tc      (b_tc),
        .load_err(b_load_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_a();
        @(negedge clk);
        #1;
    endtask

    task automatic edge_b();
        @(posedge clk);
        #1;
    endtask

    int exp_a;
    int exp_b;

    initial begin
        reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
        b_reset = 1'b1; b_en = 1'b0; b_up_dn = 1'b1; b_load = 1'b0; b_load_val = 3'd0;

        // ---- reset state ----
        edge_a();
        chk("rst_count",   {4'd0, count},    8'd0);
        chk("rst_count_n", {4'd0, count_n},  8'h0F);
        chk("rst_err",     {7'd0, load_err}, 8'd0);
        chk("rst_tc",      {7'd0, tc},       8'd0);

        // ---- 1: count up 0..9,0 ----
        reset = 1'b0; en = 1'b1; up_dn = 1'b1;
        #1;
        chk("up_tc_start", {7'd0, tc}, 8'd0);
        exp_a = 0;
        for (int n = 0; n < 10; n++) begin
            edge_a();
            exp_a = (exp_a + 1) % 10;
            chk("up_count", {4'd0, count}, 8'(exp_a));
            chk("up_tc",    {7'd0, tc},    {7'd0, (exp_a == 9)});
        end

        // ---- 2: count down from reset 0 -> 9 .. 0 -> 9 ----
        reset = 1'b1; en = 1'b0;
        edge_a();
        chk("dn_rst", {4'd0, count}, 8'd0);
        reset = 1'b0; en = 1'b1; up_dn = 1'b0;
        #1;
        chk("dn_tc_start", {7'd0, tc}, 8'd1);
        exp_a = 0;
        for (int n = 0; n < 11; n++) begin
            edge_a();
            exp_a = (exp_a + 9) % 10;
            chk("dn_count", {4'd0, count}, 8'(exp_a));
            chk("dn_tc",    {7'd0, tc},    {7'd0, (exp_a == 0)});
        end

        // ---- 3: loads in and out of range ----
        load = 1'b1; load_val = 4'd7; up_dn = 1'b1;
        edge_a();
        chk("ld7_count", {4'd0, count},    8'd7);
        chk("ld7_err",   {7'd0, load_err}, 8'd0);
        load_val = 4'd12;
        edge_a();
        chk("ld12_count",   {4'd0, count},    8'd9);
        chk("ld12_count_n", {4'd0, count_n},  8'd6);
        chk("ld12_err",     {7'd0, load_err}, 8'd1);
        load_val = 4'd9;
        edge_a();
        chk("ld9_count", {4'd0, count},    8'd9);
        chk("ld9_err",   {7'd0, load_err}, 8'd0);
        load_val = 4'd10;
        edge_a();
        chk("ld10_count", {4'd0, count},    8'd9);
        chk("ld10_err",   {7'd0, load_err}, 8'd1);
        load = 1'b0; en = 1'b0;
        edge_a();
        chk("hold9_count", {4'd0, count},    8'd9);
        chk("err_clear",   {7'd0, load_err}, 8'd0);

        // ---- 4: reset beats load mid-count ----
        reset = 1'b1;
        edge_a();
        reset = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int n = 0; n < 5; n++) edge_a();
        chk("to5_count", {4'd0, count}, 8'd5);
        reset = 1'b1; load = 1'b1; load_val = 4'd3;
        edge_a();
        chk("rst_win_count", {4'd0, count},    8'd0);
        chk("rst_win_err",   {7'd0, load_err}, 8'd0);
        reset = 1'b0; load = 1'b0;
        edge_a();
        chk("resume_count", {4'd0, count}, 8'd1);

        // ---- 5: hold at 4 while up_dn toggles ----
        load = 1'b1; load_val = 4'd4;
        edge_a();
        chk("ld4_count", {4'd0, count}, 8'd4);
        load = 1'b0; en = 1'b0;
        for (int n = 0; n < 3; n++) begin
            up_dn = n[0];
            #1;
            chk("hold_tc_pre", {7'd0, tc}, 8'd0);
            edge_a();
            chk("hold_count", {4'd0, count}, 8'd4);
            chk("hold_tc",    {7'd0, tc},    8'd0);
        end

        // ---- 6a: falling-edge instance ignores the rising edge ----
        en = 1'b1; up_dn = 1'b1;
        edge_b();
        chk("a_no_pos", {4'd0, count}, 8'd4);
        edge_a();
        chk("a_neg", {4'd0, count}, 8'd5);
        en = 1'b0;

        // ---- 6b: rising-edge W=3/M=8 instance, natural wrap 7 -> 0 ----
        edge_b();
        chk("b_rst_count", {5'd0, b_count},   8'd0);
        chk("b_rst_n",     {5'd0, b_count_n}, 8'h07);
        b_reset = 1'b0; b_en = 1'b1; b_up_dn = 1'b1;
        exp_b = 0;
        for (int n = 0; n < 8; n++) begin
            edge_a();
            chk("b_no_neg", {5'd0, b_count}, 8'(exp_b));
            edge_b();
            exp_b = (exp_b + 1) % 8;
            chk("b_up_count", {5'd0, b_count}, 8'(exp_b));
            chk("b_up_tc",    {7'd0, b_tc},    {7'd0, (exp_b == 7)});
        end
        b_up_dn = 1'b0;
        #1;
        chk("b_dn_tc", {7'd0, b_tc}, 8'd1);
        edge_b();
        chk("b_dn_wrap", {5'd0, b_count},    8'd7);
        chk("b_err",     {7'd0, b_load_err}, 8'd0);
        chk("a_still5",  {4'd0, count},      8'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
